// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared mode and state types for the 2x2 pooling engine
package pool_pkg;
   typedef enum logic {POOL_MAX = 1'b0, POOL_AVG = 1'b1} pool_mode_e;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} pool_state_e;
endpackage

// File: rtl/pool_combine.sv
// rtl/pool_combine.sv - signed max (or sum when POOL_AVG_EN is defined) of two operands, one bit wider
module pool_combine
   import pool_pkg::*;
#(
   parameter int W = 22
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         mode,
   output logic [W:0]   y
);
   logic signed [W:0] a_ext;
   logic signed [W:0] b_ext;

   assign a_ext = {a[W-1], a};
   assign b_ext = {b[W-1], b};

`ifdef POOL_AVG_EN
   always_comb begin
      if (mode == POOL_AVG) y = a_ext + b_ext;
      else                  y = (a_ext > b_ext) ? a_ext : b_ext;
   end
`else
   assign y = (a_ext > b_ext) ? a_ext : b_ext;
`endif
endmodule

// File: rtl/pool2d_stream.sv
// rtl/pool2d_stream.sv - 2x2 stride-2 max/average pooling over a raster pixel stream
// Average mode is only built when POOL_AVG_EN is defined; otherwise the block always max-pools.
module pool2d_stream
   import pool_pkg::*;
#(
   parameter int DATA_W     = 22,
   parameter int IMG_WIDTH  = 32,
   parameter int IMG_HEIGHT = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              pool_mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done
);
   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);
   localparam int HW = IMG_WIDTH / 2;
   localparam int IW = (HW > 1) ? $clog2(HW) : 1;

   generate
      if (IMG_WIDTH < 2 || (IMG_WIDTH % 2) != 0) begin : g_bad_width
         $error("pool2d_stream: IMG_WIDTH must be even and >= 2");
      end
      if (IMG_HEIGHT < 2 || (IMG_HEIGHT % 2) != 0) begin : g_bad_height
         $error("pool2d_stream: IMG_HEIGHT must be even and >= 2");
      end
   endgenerate

   pool_state_e       state;
   pool_state_e       state_nx;
   pool_mode_e        mode_q;
   logic [XW-1:0]     cnt_x;
   logic [YW-1:0]     cnt_y;
   logic [DATA_W-1:0] d1;
   logic [DATA_W:0]   linebuf [HW];
   logic [DATA_W:0]   pair;
   logic [DATA_W+1:0] quad;
   logic [DATA_W-1:0] result;
   logic [IW-1:0]     lb_idx;
   logic              accept;
   logic              last_x;
   logic              last_y;
   logic              start_ok;

   assign accept   = in_valid && in_ready;
   assign last_x   = (cnt_x == XW'(IMG_WIDTH - 1));
   assign last_y   = (cnt_y == YW'(IMG_HEIGHT - 1));
   assign lb_idx   = IW'(cnt_x >> 1);
   assign start_ok = (state == IDLE) && start;

   pool_combine #(.W(DATA_W)) u_horiz (
      .a    (d1),
      .b    (in_data),
      .mode (mode_q),
      .y    (pair)
   );

   pool_combine #(.W(DATA_W + 1)) u_vert (
      .a    (linebuf[lb_idx]),
      .b    (pair),
      .mode (mode_q),
      .y    (quad)
   );

   // Dropping the two low bits of the wide sum is the floor-divide by four.
   always_comb begin
      result = quad[DATA_W-1:0];
`ifdef POOL_AVG_EN
      if (mode_q == POOL_AVG) result = quad[DATA_W+1:2];
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (accept && last_x && last_y) state_nx = DRAIN;
         DRAIN:   if (!out_valid || out_ready) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == RUN) || (state == DRAIN);
      done     = (state == DONE);
      in_ready = (state == RUN) && (!out_valid || out_ready);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q <= POOL_MAX;
      end else if (start_ok) begin
`ifdef POOL_AVG_EN
         mode_q <= pool_mode_e'(pool_mode);
`else
         mode_q <= POOL_MAX;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_x     <= '0;
         cnt_y     <= '0;
         d1        <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (start_ok) begin
            cnt_x <= '0;
            cnt_y <= '0;
         end else if (accept) begin
            if (last_x) begin
               cnt_x <= '0;
               cnt_y <= last_y ? '0 : cnt_y + 1'b1;
            end else begin
               cnt_x <= cnt_x + 1'b1;
            end
            if (!cnt_x[0]) d1 <= in_data;
         end
         // A completing window reloads the register even while the old result is consumed.
         if (accept && cnt_x[0] && cnt_y[0]) begin
            out_valid <= 1'b1;
            out_data  <= result;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept && cnt_x[0] && !cnt_y[0]) linebuf[lb_idx] <= pair;
   end
endmodule

// File: tb/tb_pool2d_stream.sv
// tb/tb_pool2d_stream.sv - directed and randomly stalled checks of pool2d_stream on a 4x4 frame (POOL_AVG_EN aware)
module tb_pool2d_stream;
   localparam int DW   = 8;
   localparam int W    = 4;
   localparam int H    = 4;
   localparam int NPIX = W * H;
`ifdef POOL_AVG_EN
   localparam bit AVG_BUILT = 1'b1;
`else
   localparam bit AVG_BUILT = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic                 pool_mode;
   logic                 in_valid;
   logic                 in_ready;
   logic [DW-1:0]        in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [DW-1:0] out_data;
   logic                 busy;
   logic                 done;

   pool2d_stream #(.DATA_W(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pool_mode (pool_mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int pix [NPIX];
   int got_q [$];
   int exp_q [$];
   int cyc = 0, last_ov = 0, done_cyc = 0, done_cnt = 0, sent = 0, base = 0;
   bit stall = 1'b0;
   bit rand_ready = 1'b0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (out_valid) last_ov = cyc;
      if (out_valid && out_ready) got_q.push_back(int'(out_data));
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic kick(input bit m);
      start = 1'b1;
      pool_mode = m;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input int first, input int last);
      int guard = 0;
      sent = first;
      while (sent < last && guard < 2000) begin
         in_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_data  = DW'(pix[sent]);
         @(negedge clk);
         if (in_valid && in_ready) sent++;
         tick();
         guard++;
      end
      in_valid = 1'b0;
      check("send_complete", sent, last);
   endtask

   task automatic wait_done();
      int g = 0;
      while (done_cnt == base && g < 500) begin
         tick();
         g++;
      end
      repeat (3) tick();
      check("done_pulses", done_cnt, base + 1);
   endtask

   task automatic cmp_outputs(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s_%0d", tag, i), (i < got_q.size()) ? got_q[i] : -9999, exp_q[i]);
   endtask

   function automatic void model(input bit m);
      int a, b, c, d, v;
      exp_q.delete();
      for (int r = 0; r < H; r += 2)
         for (int k = 0; k < W; k += 2) begin
            a = pix[r*W + k];
            b = pix[r*W + k + 1];
            c = pix[(r+1)*W + k];
            d = pix[(r+1)*W + k + 1];
            if (m && AVG_BUILT) v = (a + b + c + d) >>> 2;
            else begin
               v = a;
               if (b > v) v = b;
               if (c > v) v = c;
               if (d > v) v = d;
            end
            exp_q.push_back(v);
         end
   endfunction

   task automatic run_frame(input bit m, input bit st, input string tag);
      base = done_cnt;
      got_q.delete();
      stall = st;
      rand_ready = st;
      if (!st) out_ready = 1'b1;
      kick(m);
      send(0, NPIX);
      wait_done();
      rand_ready = 1'b0;
      stall = 1'b0;
      out_ready = 1'b1;
      cmp_outputs(tag);
   endtask

   task automatic load_ramp();
      for (int i = 0; i < NPIX; i++) pix[i] = i;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; pool_mode = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      tick();
      rst = 1'b1;
      tick();

      load_ramp();
      exp_q = '{5, 7, 13, 15};
      run_frame(1'b0, 1'b0, "max_ramp");
      check("done_latency", done_cyc - last_ov, 1);
      check("idle_busy", busy, 0);

      if (AVG_BUILT) exp_q = '{2, 4, 10, 12};
      else           exp_q = '{5, 7, 13, 15};
      run_frame(1'b1, 1'b0, "avg_ramp");

      pix = '{-1, -2, -1, 0, -3, -4, 0, 0, 127, 127, -128, -128, 127, 127, -128, -128};
      exp_q = '{-1, 0, 127, -128};
      run_frame(1'b0, 1'b0, "neg_max");
      if (AVG_BUILT) exp_q = '{-3, -1, 127, -128};
      else           exp_q = '{-1, 0, 127, -128};
      run_frame(1'b1, 1'b0, "neg_avg");

      load_ramp();
      base = done_cnt;
      got_q.delete();
      out_ready = 1'b0;
      kick(1'b0);
      fork
         send(0, NPIX);
         begin
            int g = 0;
            while (!out_valid && g < 100) begin
               tick();
               g++;
            end
            repeat (8) tick();
            @(negedge clk);
            check("bp_hold_data", out_data, 5);
            check("bp_hold_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_frozen", sent, 6);
            tick();
            out_ready = 1'b1;
         end
      join
      wait_done();
      exp_q = '{5, 7, 13, 15};
      cmp_outputs("bp");

      base = done_cnt;
      out_ready = 1'b0;
      kick(1'b0);
      send(0, 6);
      @(negedge clk);
      check("abort_pending", out_valid, 1);
      rst = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      tick();
      rst = 1'b1;
      out_ready = 1'b1;
      repeat (5) tick();
      check("abort_no_done", done_cnt, base);
      run_frame(1'b0, 1'b0, "after_abort");

      base = done_cnt;
      got_q.delete();
      kick(1'b0);
      send(0, 3);
      start = 1'b1;
      tick();
      start = 1'b0;
      send(3, NPIX);
      wait_done();
      cmp_outputs("start_in_run");

      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < NPIX; i++) pix[i] = int'($urandom_range(0, 255)) - 128;
         model(k[0]);
         run_frame(k[0], 1'b1, $sformatf("rand%0d", k));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
